// File: rtl/exec_pkg.sv
// Shared types and constants for the execute stage: op codes, FSM states and
// the iteration count of the shift-add multiplier.
package exec_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_MUL = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam int MUL_CYCLES = 16;
  localparam int CNT_BITS   = $clog2(MUL_CYCLES);

endpackage

// File: rtl/exec_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per clock while
// step is high; done flags the final step and result carries its sum.
module exec_mul_iter
  import exec_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  logic [CNT_BITS-1:0] cnt_reg;
  logic [WIDTH-1:0]    acc_reg;
  logic [WIDTH-1:0]    mcand_reg;
  logic [WIDTH-1:0]    mplier_reg;
  logic [WIDTH-1:0]    acc_next;

  assign acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
  // result is the accumulator after the current step, so the final sum is
  // available in the same cycle done is raised.
  assign done     = step && (cnt_reg == CNT_BITS'(MUL_CYCLES - 1));
  assign result   = acc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
    end else if (start) begin
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mcand_reg  <= opa;
      mplier_reg <= opb;
    end else if (step) begin
      cnt_reg    <= cnt_reg + 1'b1;
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage feeding the register-file write port: single-cycle ALU ops and
// a 16-cycle iterative multiply that back-pressures the issuer.
module exec_unit
  import exec_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int NREG_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic [NREG_BITS-1:0] rd,
  input  logic [WIDTH-1:0]     opa,
  input  logic [WIDTH-1:0]     opb,
  output logic                 wb_en,
  output logic [NREG_BITS-1:0] wb_reg,
  output logic [WIDTH-1:0]     wb_data,
  output logic                 busy
);

  state_t               state_reg, state_next;
  logic                 wb_en_reg, wb_en_next;
  logic [NREG_BITS-1:0] wb_idx_reg, wb_idx_next;
  logic [WIDTH-1:0]     wb_data_reg, wb_data_next;
  // Destination of the multiply in flight, kept apart so wb_reg holds meanwhile.
  logic [NREG_BITS-1:0] mul_rd_reg, mul_rd_next;

  op_t              op_sel;
  logic             accept;
  logic             mul_start;
  logic             mul_step;
  logic             mul_done;
  logic [WIDTH-1:0] mul_result;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       shamt;

  assign op_sel   = op_t'(op);
  assign in_ready = (state_reg != MUL);
  assign busy     = (state_reg == MUL);
  assign accept   = in_valid && in_ready;
  assign mul_step = (state_reg == MUL);
  assign shamt    = opb[3:0];

  assign wb_en   = wb_en_reg;
  assign wb_reg  = wb_idx_reg;
  assign wb_data = wb_data_reg;

  exec_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .step   (mul_step),
    .opa    (opa),
    .opb    (opb),
    .done   (mul_done),
    .result (mul_result)
  );

  always_comb begin
    alu_result = '0;
    case (op_sel)
      OP_ADD:  alu_result = opa + opb;
      OP_SUB:  alu_result = opa - opb;
      OP_AND:  alu_result = opa & opb;
      OP_OR:   alu_result = opa | opb;
      OP_XOR:  alu_result = opa ^ opb;
      OP_SLL:  alu_result = opa << shamt;
      OP_SRL:  alu_result = opa >> shamt;
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    wb_en_next   = 1'b0;
    wb_idx_next  = wb_idx_reg;
    wb_data_next = wb_data_reg;
    mul_rd_next  = mul_rd_reg;
    mul_start    = 1'b0;
    case (state_reg)
      MUL: begin
        if (mul_done) begin
          state_next   = WB;
          wb_en_next   = 1'b1;
          wb_idx_next  = mul_rd_reg;
          wb_data_next = mul_result;
        end
      end
      default: begin
        if (accept) begin
          if (op_sel == OP_MUL) begin
            state_next  = MUL;
            mul_start   = 1'b1;
            mul_rd_next = rd;
          end else begin
            state_next   = WB;
            wb_en_next   = 1'b1;
            wb_idx_next  = rd;
            wb_data_next = alu_result;
          end
        end else begin
          state_next = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      wb_en_reg   <= 1'b0;
      wb_idx_reg  <= '0;
      wb_data_reg <= '0;
      mul_rd_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      wb_en_reg   <= wb_en_next;
      wb_idx_reg  <= wb_idx_next;
      wb_data_reg <= wb_data_next;
      mul_rd_reg  <= mul_rd_next;
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed cases plus random traffic, all
// compared against a timeline-based reference model of accepts and writebacks.
module tb_exec_unit;
  import exec_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'd0;
  logic [2:0]  rd = 3'd0;
  logic [15:0] opa = 16'd0;
  logic [15:0] opb = 16'd0;
  logic        wb_en;
  logic [2:0]  wb_reg;
  logic [15:0] wb_data;
  logic        busy;

  exec_unit #(
    .WIDTH(16),
    .NREG_BITS(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .rd       (rd),
    .opa      (opa),
    .opb      (opb),
    .wb_en    (wb_en),
    .wb_reg   (wb_reg),
    .wb_data  (wb_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expected writeback: visible in the cycle following clock edge at_edge.
  typedef struct {
    int          at_edge;
    logic [2:0]  idx;
    logic [15:0] data;
  } wb_t;

  wb_t         exp_q[$];
  int          edge_cnt = 0;
  int          ready_from = 0;
  logic [2:0]  last_idx = 3'd0;
  logic [15:0] last_data = 16'd0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_cnt);
    end
  endtask

  function automatic logic [15:0] ref_result(input logic [2:0] o, input logic [15:0] a,
                                             input logic [15:0] b);
    int unsigned ua, ub, sh, r;
    ua = a;
    ub = b;
    sh = ub % 16;
    case (o)
      3'd0: r = (ua + ub) % 65536;
      3'd1: r = (ua + 65536 - ub) % 65536;
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = (ua * (1 << sh)) % 65536;
      3'd6: r = ua / (1 << sh);
      default: r = (ua * ub) % 65536;
    endcase
    return 16'(r);
  endfunction

  // Present one cycle of stimulus, check the outputs of that cycle, then
  // advance the model across the next rising edge.
  task automatic step(input logic v, input logic [2:0] o, input logic [2:0] r,
                      input logic [15:0] a, input logic [15:0] b);
    logic exp_ready;
    logic hit;
    wb_t  w;
    in_valid = v;
    op       = o;
    rd       = r;
    opa      = a;
    opb      = b;
    @(negedge clk);
    exp_ready = (edge_cnt >= ready_from);
    hit = (exp_q.size() > 0) && (exp_q[0].at_edge == edge_cnt);
    check_val("in_ready", in_ready, exp_ready);
    check_val("busy", busy, !exp_ready);
    check_val("wb_en", wb_en, hit);
    if (hit) begin
      w = exp_q.pop_front();
      last_idx  = w.idx;
      last_data = w.data;
      $display("wb r%0d <= %04h (edge %0d)", w.idx, w.data, edge_cnt);
    end
    check_val("wb_reg", wb_reg, last_idx);
    check_val("wb_data", wb_data, last_data);
    @(posedge clk);
    edge_cnt++;
    if (v && exp_ready) begin
      w.idx  = r;
      w.data = ref_result(o, a, b);
      if (o == 3'd7) begin
        w.at_edge  = edge_cnt + MUL_CYCLES;
        ready_from = edge_cnt + MUL_CYCLES;
      end else begin
        w.at_edge = edge_cnt;
      end
      exp_q.push_back(w);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 3'd0, 16'd0, 16'd0);
  endtask

  // Called away from a clock edge; reset must take effect without a clock.
  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check_val("rst_wb_en", wb_en, 1'b0);
    check_val("rst_wb_reg", wb_reg, 3'd0);
    check_val("rst_wb_data", wb_data, 16'd0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    edge_cnt   = 0;
    ready_from = 0;
    last_idx   = 3'd0;
    last_data  = 16'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    #2;
    do_reset();

    step(1'b1, OP_ADD, 3'd2, 16'h1234, 16'h0001);
    idle(2);
    step(1'b1, OP_SUB, 3'd5, 16'h0000, 16'h0001);
    step(1'b1, OP_SLL, 3'd1, 16'h0001, 16'h0013);
    step(1'b1, OP_SRL, 3'd6, 16'h8000, 16'h000F);
    idle(1);

    step(1'b1, OP_MUL, 3'd3, 16'h0123, 16'h0010);
    idle(18);
    step(1'b1, OP_MUL, 3'd7, 16'hFFFF, 16'hFFFF);
    idle(18);

    step(1'b1, OP_ADD, 3'd1, 16'h0100, 16'h0023);
    step(1'b1, OP_XOR, 3'd4, 16'hF0F0, 16'h0FF0);
    idle(2);

    // ADD held valid throughout the multiply; accepted once ready returns.
    step(1'b1, OP_MUL, 3'd6, 16'h00AB, 16'h0102);
    for (int i = 0; i < MUL_CYCLES + 1; i++) step(1'b1, OP_ADD, 3'd2, 16'h1111, 16'h2222);
    idle(2);

    // Accept a multiply in the WB cycle of an ALU op.
    step(1'b1, OP_OR, 3'd5, 16'h0F00, 16'h00F0);
    step(1'b1, OP_MUL, 3'd4, 16'h1234, 16'h5678);
    idle(18);

    // Abort a multiply five cycles in; its writeback must never appear.
    step(1'b1, OP_MUL, 3'd3, 16'h0123, 16'h0010);
    idle(5);
    do_reset();
    idle(20);
    step(1'b1, OP_ADD, 3'd7, 16'h7FFF, 16'h0001);
    idle(2);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           16'($urandom), 16'($urandom));
    end
    idle(MUL_CYCLES + 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
# exec_unit

Execute stage that sits directly upstream of the 8 x 16-bit register file. It accepts an operation with two 16-bit operands (the register file's two read ports) and a destination register index. It computes the result and drives the register file's write port for one cycle. Logic and add/shift ops complete in one cycle; MUL uses an iterative 16-cycle shift-add multiplier, during which the stage back-pressures its issuer.

## Interface
Parameters:
- WIDTH, 16, data width (operands, result).
- NREG_BITS, 3, destination index width (8 registers).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; one clock, reset asynchronous and active-high.
- in_valid  in  1  issuer presents an operation.
- in_ready  out  1  stage can accept this cycle.
- op  in  3  operation code (package enum).
- rd  in  NREG_BITS  destination register index.
- opa  in  WIDTH  operand A.
- opb  in  WIDTH  operand B.
- wb_en  out  1  register-file write enable, one-cycle pulse per result.
- wb_reg  out  NREG_BITS  register-file write index.
- wb_data  out  WIDTH  register-file write data.
- busy  out  1  multiply in progress.

## Operation
- Op codes:
  - 0 ADD: opa+opb, mod 2^16.
  - 1 SUB: opa-opb, mod 2^16.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SLL: opa << opb[3:0].
  - 6 SRL: opa >> opb[3:0], logical.
  - 7 MUL: low 16 bits of opa*opb.
- Shift amounts use only opb[3:0]; opb[15:4] is ignored.
- No carry, overflow or flag outputs. rd=0 has no special meaning.
- Accept occurs when in_valid && in_ready on a rising clk. op, rd, opa and opb are sampled only at accept.
- States: IDLE, MUL, WB.
- in_ready = (state != MUL), combinational from state.
- Transitions:
  - IDLE/WB with accept of op 0-6 → WB. wb_data is the registered result, wb_reg is the registered rd, and wb_en=1.
  - IDLE/WB with accept of op 7 → MUL. cnt=0, acc=0, mcand=opa, mplier=opb, wb_en=0.
  - IDLE/WB with no accept → IDLE, wb_en=0.
  - MUL, each edge: if mplier[0], acc += mcand (mod 2^16); then mcand <<= 1, mplier >>= 1, cnt++. When cnt==15 at the edge → WB with wb_data = final acc and wb_en=1.
- wb_reg and wb_data hold their last values when wb_en=0.
- busy = (state == MUL).

## Timing
- Reset values:
  - state IDLE.
  - wb_en 0, wb_reg 0, wb_data 0.
  - busy 0, in_ready 1.
  - cnt, acc, mcand and mplier all 0.
- ALU latency: accept at edge N → wb_en high for the cycle after edge N.
- MUL latency: accept at edge N → iterations at edges N+1..N+16. wb_en is high for the cycle after edge N+16, and in_ready is low for those 16 cycles.
- Throughput: one ALU op per cycle; back-to-back accepts give consecutive wb_en cycles with new wb_reg and wb_data each cycle.
- An accept in WB is permitted, including MUL: the WB cycle's writeback still completes and the next state is MUL.
- in_valid while in MUL: ignored, and the issuer must hold the operation. in_valid may drop without penalty.
- Reset mid-MUL: aborts immediately. No wb_en is produced for the aborted op, and the stage is ready on the first edge after rst deasserts.
- Reset during the WB cycle: wb_en drops asynchronously, so that writeback may be lost.

## Structure
- Package exec_pkg:
  - op_t enum (OP_ADD..OP_MUL, 3-bit).
  - state_t enum (IDLE, MUL, WB).
  - MUL_CYCLES = 16.
- Sub-module exec_mul_iter:
  - Contains the iterative shift-add multiplier with start, done and result ports.
  - Holds cnt, acc, mcand and mplier.
  - Its reset is the same asynchronous active-high rst.
- The top module keeps the FSM, ALU mux and writeback registers.

## Test plan
- Reset, then ADD opa=0x1234 opb=0x0001 rd=2 → next cycle wb_en=1, wb_reg=2, wb_data=0x1235; wb_en=0 the cycle after.
- SUB 0x0000-0x0001 rd=5 → wb_data=0xFFFF. SLL opa=0x0001 opb=0x0013 → wb_data=0x0008 (only opb[3:0]=3 used). SRL 0x8000 by 15 → 0x0001.
- MUL 0x0123*0x0010 rd=3 → in_ready=0 and busy=1 for 16 cycles, then wb_en=1 with wb_data=0x1230 and wb_reg=3. Also MUL 0xFFFF*0xFFFF → 0x0001.
- Back-to-back ADD (rd=1) then XOR 0xF0F0^0x0FF0 (rd=4) on consecutive edges → wb_en high two consecutive cycles: first wb_reg=1, then wb_reg=4 with wb_data=0xFF00.
- During MUL, hold in_valid=1 with ADD → not accepted until in_ready returns; ADD writeback follows MUL writeback by exactly one cycle.
- Assert rst 5 cycles into a MUL → wb_en never asserts for it, outputs return to reset values immediately, and a subsequent ADD completes normally.
